// File: rtl/musicbox_sdram_arbiter_if.sv
// rtl/musicbox_sdram_arbiter_if.sv - requester and SDRAM-controller signal bundle for the two-port arbiter
interface musicbox_sdram_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              req0_valid, req0_write, req0_ready, req0_rvalid, req0_done;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata, req0_rdata;
    logic              req1_valid, req1_write, req1_ready, req1_rvalid, req1_done;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata, req1_rdata;
    logic [ADDR_W-1:0] sdram_inputAddress;
    logic [DATA_W-1:0] sdram_writeData, sdram_readData;
    logic              sdram_isWriting, sdram_inputValid;
    logic              sdram_outputValid, sdram_recievedCommand, sdram_isBusy;
    logic [1:0]        grant;
    logic              timeout_error;

    modport slave (
        input  req0_valid, req0_addr, req0_wdata, req0_write,
        input  req1_valid, req1_addr, req1_wdata, req1_write,
        input  sdram_readData, sdram_outputValid, sdram_recievedCommand, sdram_isBusy,
        output req0_ready, req0_rdata, req0_rvalid, req0_done,
        output req1_ready, req1_rdata, req1_rvalid, req1_done,
        output sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid,
        output grant, timeout_error
    );

    modport master (
        output req0_valid, req0_addr, req0_wdata, req0_write,
        output req1_valid, req1_addr, req1_wdata, req1_write,
        output sdram_readData, sdram_outputValid, sdram_recievedCommand, sdram_isBusy,
        input  req0_ready, req0_rdata, req0_rvalid, req0_done,
        input  req1_ready, req1_rdata, req1_rvalid, req1_done,
        input  sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid,
        input  grant, timeout_error
    );
endinterface

// File: rtl/musicbox_sdram_arbiter.sv
// rtl/musicbox_sdram_arbiter.sv - round-robin arbiter sharing one SDRAM controller between recorder and playback
module musicbox_sdram_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clock_50Mhz,
    input  logic                     reset_n,
    musicbox_sdram_arbiter_if.slave  bus
);
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} state_t;

    state_t            state_q;
    logic              owner_q, last_q, write_q, settled_q, terr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [1:0]        grant_q, ready_q, done_q, rvalid_q;

    logic owner_d, any_req, finish_ok, finish_to;

    assign any_req = bus.req0_valid | bus.req1_valid;
    // A tie goes to whoever was not served last; a lone requester always wins.
    assign owner_d = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
    assign tcnt_d  = tcnt_q + CNT_W'(1);

    // Writes ignore isBusy on the first WAIT_DONE cycle: the controller may not have raised it yet.
    assign finish_ok = (state_q == WAIT_DONE) &
                       (write_q ? (settled_q & ~bus.sdram_isBusy) : bus.sdram_outputValid);
    assign finish_to = (state_q != IDLE) & ~finish_ok & (tcnt_q == CNT_LAST);

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            write_q   <= 1'b0;
            settled_q <= 1'b0;
            terr_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            tcnt_q    <= '0;
            grant_q   <= 2'b00;
            ready_q   <= 2'b00;
            done_q    <= 2'b00;
            rvalid_q  <= 2'b00;
        end else begin
            ready_q  <= 2'b00;
            done_q   <= 2'b00;
            rvalid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= ISSUE;
                        owner_q   <= owner_d;
                        last_q    <= owner_d;
                        addr_q    <= owner_d ? bus.req1_addr  : bus.req0_addr;
                        wdata_q   <= owner_d ? bus.req1_wdata : bus.req0_wdata;
                        write_q   <= owner_d ? bus.req1_write : bus.req0_write;
                        grant_q   <= owner_d ? 2'b10 : 2'b01;
                        ready_q   <= owner_d ? 2'b10 : 2'b01;
                        tcnt_q    <= '0;
                        settled_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    tcnt_q <= tcnt_d;
                    if (bus.sdram_recievedCommand) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    tcnt_q    <= tcnt_d;
                    settled_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase

            if (finish_ok && !write_q) begin
                if (owner_q) rdata1_q <= bus.sdram_readData;
                else         rdata0_q <= bus.sdram_readData;
                rvalid_q <= grant_q;
            end

            if (finish_ok || finish_to) begin
                state_q <= IDLE;
                done_q  <= grant_q;
                grant_q <= 2'b00;
                addr_q  <= '0;
                wdata_q <= '0;
                write_q <= 1'b0;
                if (finish_to) terr_q <= 1'b1;
            end
        end
    end

    assign bus.req0_ready         = ready_q[0];
    assign bus.req1_ready         = ready_q[1];
    assign bus.req0_done          = done_q[0];
    assign bus.req1_done          = done_q[1];
    assign bus.req0_rvalid        = rvalid_q[0];
    assign bus.req1_rvalid        = rvalid_q[1];
    assign bus.req0_rdata         = rdata0_q;
    assign bus.req1_rdata         = rdata1_q;
    assign bus.grant              = grant_q;
    assign bus.timeout_error      = terr_q;
    assign bus.sdram_inputAddress = addr_q;
    assign bus.sdram_writeData    = wdata_q;
    assign bus.sdram_isWriting    = write_q;
    assign bus.sdram_inputValid   = (state_q == ISSUE) & ~bus.sdram_isBusy;
endmodule

// File: tb/tb_musicbox_sdram_arbiter.sv
// tb/tb_musicbox_sdram_arbiter.sv - directed and randomized checks of the SDRAM arbiter against a transaction-level model
module tb_musicbox_sdram_arbiter;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int TO     = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    musicbox_sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    musicbox_sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clock_50Mhz (clk),
        .reset_n     (rst_n),
        .bus         (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int cyc, done_cyc, t_iv, t_g01, t_gother, t_coinc;
    int t_ready [2];
    int t_done  [2];
    int t_rvalid[2];
    int won[$];
    int alt_exp[4] = '{0, 1, 0, 1};

    // Transaction-level model: one outstanding command and its history.
    logic              m_busy, m_acked, m_write, m_terr;
    int                m_owner, m_last, m_age, m_wait;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata[2];
    logic [1:0]        e_ready, e_done, e_rvalid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_acked = 1'b0; m_write = 1'b0; m_terr = 1'b0;
        m_owner = 0; m_last = 1; m_age = 0; m_wait = 0;
        m_addr = '0; m_wdata = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        e_ready = 2'b00; e_done = 2'b00; e_rvalid = 2'b00;
    endtask

    task automatic model_edge();
        logic fin;
        e_ready = 2'b00; e_done = 2'b00; e_rvalid = 2'b00;
        if (!m_busy) begin
            if (bus.req0_valid || bus.req1_valid) begin
                if (bus.req0_valid && bus.req1_valid) m_owner = 1 - m_last;
                else                                  m_owner = bus.req1_valid ? 1 : 0;
                m_last  = m_owner;
                m_busy  = 1'b1;
                m_acked = 1'b0;
                m_age   = 0;
                m_wait  = 0;
                m_addr  = (m_owner == 1) ? bus.req1_addr  : bus.req0_addr;
                m_wdata = (m_owner == 1) ? bus.req1_wdata : bus.req0_wdata;
                m_write = (m_owner == 1) ? bus.req1_write : bus.req0_write;
                e_ready[m_owner] = 1'b1;
            end
        end else begin
            fin = 1'b0;
            if (!m_acked) begin
                m_acked = bus.sdram_recievedCommand;
            end else begin
                if (!m_write && bus.sdram_outputValid) begin
                    fin = 1'b1;
                    m_rdata[m_owner] = bus.sdram_readData;
                    e_rvalid[m_owner] = 1'b1;
                end else if (m_write && m_wait >= 1 && !bus.sdram_isBusy) begin
                    fin = 1'b1;
                end
                m_wait++;
            end
            if (!fin && m_age == TO - 1) begin
                fin = 1'b1;
                m_terr = 1'b1;
            end
            m_age++;
            if (fin) begin
                m_busy = 1'b0;
                e_done[m_owner] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [1:0] g;
        g = !m_busy ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
        chk("req0_ready",  64'(bus.req0_ready),  64'(e_ready[0]));
        chk("req1_ready",  64'(bus.req1_ready),  64'(e_ready[1]));
        chk("req0_done",   64'(bus.req0_done),   64'(e_done[0]));
        chk("req1_done",   64'(bus.req1_done),   64'(e_done[1]));
        chk("req0_rvalid", 64'(bus.req0_rvalid), 64'(e_rvalid[0]));
        chk("req1_rvalid", 64'(bus.req1_rvalid), 64'(e_rvalid[1]));
        chk("req0_rdata",  64'(bus.req0_rdata),  64'(m_rdata[0]));
        chk("req1_rdata",  64'(bus.req1_rdata),  64'(m_rdata[1]));
        chk("grant",       64'(bus.grant),       64'(g));
        chk("timeout_error", 64'(bus.timeout_error), 64'(m_terr));
        chk("inputValid",  64'(bus.sdram_inputValid), 64'(m_busy && !m_acked && !bus.sdram_isBusy));
        chk("inputAddress", 64'(bus.sdram_inputAddress), m_busy ? 64'(m_addr) : 64'd0);
        chk("writeData",   64'(bus.sdram_writeData), m_busy ? 64'(m_wdata) : 64'd0);
        chk("isWriting",   64'(bus.sdram_isWriting), m_busy ? 64'(m_write) : 64'd0);
    endtask

    task automatic clear_tallies();
        cyc = 0; done_cyc = -1; t_iv = 0; t_g01 = 0; t_gother = 0; t_coinc = 0;
        for (int n = 0; n < 2; n++) begin t_ready[n] = 0; t_done[n] = 0; t_rvalid[n] = 0; end
        won.delete();
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (bus.req0_ready) begin t_ready[0]++; won.push_back(0); end
        if (bus.req1_ready) begin t_ready[1]++; won.push_back(1); end
        if (bus.req0_done)   t_done[0]++;
        if (bus.req1_done)   t_done[1]++;
        if (bus.req0_rvalid) t_rvalid[0]++;
        if (bus.req1_rvalid) t_rvalid[1]++;
        if (bus.req1_rvalid && bus.req1_done) t_coinc++;
        if (bus.sdram_inputValid) t_iv++;
        if (bus.grant == 2'b01) t_g01++;
        else if (bus.grant != 2'b00) t_gother++;
        if (bus.req0_done || bus.req1_done) done_cyc = cyc;
    endtask

    task automatic set_req(input int n, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic w);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_write = w;
        end else begin
            bus.req1_valid = v; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_write = w;
        end
    endtask

    task automatic set_ctrl(input logic rc, input logic ov, input logic busy, input logic [DATA_W-1:0] rd);
        bus.sdram_recievedCommand = rc;
        bus.sdram_outputValid     = ov;
        bus.sdram_isBusy          = busy;
        bus.sdram_readData        = rd;
    endtask

    task automatic auto_ctrl();
        set_ctrl(m_busy && !m_acked, m_busy && m_acked, 1'b0, DATA_W'($urandom));
    endtask

    function automatic logic cur_valid(input int n);
        return (n == 0) ? bus.req0_valid : bus.req1_valid;
    endfunction

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (cycles) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int dead;
        int phase_left;
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        set_ctrl(1'b0, 1'b0, 1'b0, '0);
        model_reset();
        #2;
        do_reset(2);
        chk("reset_grant", 64'(bus.grant), 64'd0);

        // Write from req0: ack on the second ISSUE cycle, isBusy low four cycles after the ack.
        clear_tallies();
        set_req(0, 1'b1, 25'h000010, 16'hA5A5, 1'b1);
        step();
        set_req(0, 1'b0, '0, '0, 1'b0);
        step();
        set_ctrl(1'b1, 1'b0, 1'b0, '0);
        step();
        set_ctrl(1'b0, 1'b0, 1'b1, '0);
        repeat (3) step();
        set_ctrl(1'b0, 1'b0, 1'b0, '0);
        step();
        step();
        chk("wr_ready_count", 64'(t_ready[0]), 64'd1);
        chk("wr_iv_cycles",   64'(t_iv), 64'd2);
        chk("wr_done_count",  64'(t_done[0]), 64'd1);
        chk("wr_done_cycle",  64'(done_cyc), 64'd7);
        chk("wr_grant01",     64'(t_g01), 64'd6);
        chk("wr_grant_other", 64'(t_gother), 64'd0);

        // Read from req1 at the top address.
        clear_tallies();
        set_req(1, 1'b1, 25'h1FFFFFF, 16'h0000, 1'b0);
        step();
        set_req(1, 1'b0, '0, '0, 1'b0);
        set_ctrl(1'b1, 1'b0, 1'b0, '0);
        step();
        set_ctrl(1'b0, 1'b1, 1'b0, 16'h1234);
        step();
        set_ctrl(1'b0, 1'b0, 1'b0, '0);
        step();
        chk("rd_rdata1",     64'(bus.req1_rdata), 64'h1234);
        chk("rd_rvalid1",    64'(t_rvalid[1]), 64'd1);
        chk("rd_done1",      64'(t_done[1]), 64'd1);
        chk("rd_coincident", 64'(t_coinc), 64'd1);
        chk("rd_req0_quiet", 64'(t_ready[0] + t_done[0] + t_rvalid[0]), 64'd0);
        chk("rd_rdata0",     64'(bus.req0_rdata), 64'd0);

        // isBusy held during ISSUE keeps inputValid low until it falls.
        clear_tallies();
        set_ctrl(1'b0, 1'b0, 1'b1, '0);
        set_req(0, 1'b1, 25'h0ABCDE, 16'h0000, 1'b0);
        step();
        set_req(0, 1'b0, '0, '0, 1'b0);
        step();
        step();
        chk("busy_iv_low", 64'(t_iv), 64'd0);
        set_ctrl(1'b1, 1'b0, 1'b0, '0);
        #1;
        chk("busy_iv_rise", 64'(bus.sdram_inputValid), 64'd1);
        step();
        set_ctrl(1'b0, 1'b1, 1'b0, 16'hBEEF);
        step();
        set_ctrl(1'b0, 1'b0, 1'b0, '0);
        step();
        chk("busy_rdata0", 64'(bus.req0_rdata), 64'hBEEF);

        // Controller never acknowledges: abort after TO cycles.
        clear_tallies();
        set_req(0, 1'b1, 25'h000123, 16'h0000, 1'b0);
        step();
        set_req(0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 40 && t_done[0] == 0; i++) step();
        chk("to_done_cycle", 64'(done_cyc - 1), 64'd16);
        chk("to_rvalid",     64'(t_rvalid[0]), 64'd0);
        chk("to_error_set",  64'(bus.timeout_error), 64'd1);
        repeat (5) step();
        chk("to_error_sticky", 64'(bus.timeout_error), 64'd1);

        // Reset during WAIT_DONE of a read.
        set_req(0, 1'b1, 25'h000456, 16'h0000, 1'b0);
        step();
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_ctrl(1'b1, 1'b0, 1'b0, '0);
        step();
        set_ctrl(1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_terr",  64'(bus.timeout_error), 64'd0);
        model_reset();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_tallies();
        set_ctrl(1'b0, 1'b1, 1'b0, 16'h5555);
        repeat (6) step();
        chk("rst_no_done",   64'(t_done[0] + t_done[1]), 64'd0);
        chk("rst_no_rvalid", 64'(t_rvalid[0] + t_rvalid[1]), 64'd0);
        set_ctrl(1'b0, 1'b0, 1'b0, '0);
        set_req(0, 1'b1, 25'h000001, 16'h0000, 1'b0);
        set_req(1, 1'b1, 25'h000002, 16'h0000, 1'b0);
        step();
        chk("rst_tie_winner", (won.size() > 0) ? 64'(won[0]) : 64'd99, 64'd0);

        // Both requesters valid continuously from reset: winners alternate.
        do_reset(2);
        clear_tallies();
        set_req(0, 1'b1, 25'h000100, 16'h0000, 1'b0);
        set_req(1, 1'b1, 25'h000200, 16'h0000, 1'b0);
        for (int i = 0; i < 40 && won.size() < 4; i++) begin
            auto_ctrl();
            step();
        end
        chk("alt_count", 64'(won.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("alt_grant%0d", i), (won.size() > i) ? 64'(won[i]) : 64'd99, 64'(alt_exp[i]));

        // Randomized traffic, controller stalls and occasional resets.
        dead = 0;
        phase_left = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!cur_valid(n) || e_ready[n]) begin
                    if ($urandom_range(0, 99) < 45)
                        set_req(n, 1'b1, ADDR_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)));
                    else
                        set_req(n, 1'b0, '0, '0, 1'b0);
                end
            end
            if (phase_left == 0) begin
                dead = ($urandom_range(0, 9) == 0) ? 1 : 0;
                phase_left = $urandom_range(5, 40);
            end
            phase_left--;
            if (dead != 0)
                set_ctrl(1'b0, 1'b0, 1'b1, DATA_W'($urandom));
            else
                set_ctrl($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 25,
                         $urandom_range(0, 99) < 40, DATA_W'($urandom));
            if ($urandom_range(0, 499) == 0)
                do_reset(1);
            else
                step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
